// File: rtl/fumpy_pkg.sv
// Shared types and default sizes for the result-unload path: FSM state encoding
// (also shown on the seg debug display) and word/byte geometry.
package fumpy_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned RD_LAT_DEF     = 1;
  localparam int unsigned DIM_W          = 7;
  localparam int unsigned BYTES_PER_WORD = DATA_W_DEF / 8;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HDR_R   = 4'd1,
    WAIT_H0 = 4'd2,
    HDR_C   = 4'd3,
    WAIT_H1 = 4'd4,
    RD      = 4'd5,
    RD_WAIT = 4'd6,
    SEND    = 4'd7,
    WAIT_TX = 4'd8,
    FIN     = 4'd9
  } unload_state_t;

endpackage

// File: rtl/fsm_result_unload_if.sv
// C-RAM read port plus UART TX byte handshake used by the result-unload FSM.
interface fsm_result_unload_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] ram_c_rd_addr;
  logic [DATA_W-1:0] ram_c_rd_data;
  logic [7:0]        uart_tx_data;
  logic              uart_send_data;
  logic              uart_tx_done;

  modport master (
    output ram_c_rd_addr, uart_tx_data, uart_send_data,
    input  ram_c_rd_data, uart_tx_done
  );

  modport slave (
    input  ram_c_rd_addr, uart_tx_data, uart_send_data,
    output ram_c_rd_data, uart_tx_done
  );
endinterface

// File: rtl/fsm_result_unload_byte_serializer.sv
// Holds one result word and presents it MSB byte first; each advance moves to the
// next byte and last_c flags the final byte of the word.
module fsm_result_unload_byte_serializer
  import fumpy_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NBYTES = BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              advance,
  output logic [7:0]        next_byte_c,
  output logic              last_c
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shifted_c;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = load_word;
      idx_d  = '0;
    end else if (advance) begin
      word_d = word_q << 8;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  // Byte that becomes current after the next advance.
  assign shifted_c   = word_q << 8;
  assign next_byte_c = shifted_c[DATA_W-1 -: 8];
  assign last_c      = (idx_q == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/fsm_result_unload.sv
// Streams the result matrix C out over the UART TX byte interface: a rows/cols header
// followed by every word of C in row-major order, MSB byte first.
module fsm_result_unload
  import fumpy_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] n_rows,
  input  logic [DIM_W-1:0] n_cols,
  fsm_result_unload_if.master bus,
  output logic             busy,
  output logic             unload_done,
  output logic [3:0]       state_val
);

  localparam int unsigned PROD_W = 2 * DIM_W;
  localparam int unsigned CNT_W  = (ADDR_W + 1 > PROD_W) ? ADDR_W + 1 : PROD_W;
  localparam int unsigned LAT_W  = 2;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

  unload_state_t     state_q, state_d;
  logic              start_q, start_d;
  logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              send_q, send_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ser_load_c, ser_adv_c, ser_last_c;
  logic [7:0]        ser_next_byte_c;
  logic [PROD_W-1:0] prod_c;
  logic [CNT_W-1:0]  total_c;
  logic              word_last_c;

  fsm_result_unload_byte_serializer #(
    .DATA_W (DATA_W),
    .NBYTES (DATA_W / 8)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ser_load_c),
    .load_word   (bus.ram_c_rd_data),
    .advance     (ser_adv_c),
    .next_byte_c (ser_next_byte_c),
    .last_c      (ser_last_c)
  );

  // Word count, clamped to what the C-RAM can address.
  always_comb begin
    prod_c      = PROD_W'(rows_q) * PROD_W'(cols_q);
    total_c     = (CNT_W'(prod_c) > MAX_WORDS) ? MAX_WORDS : CNT_W'(prod_c);
    word_last_c = (CNT_W'(word_idx_q) == total_c - CNT_W'(1));
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start;
    rows_d     = rows_q;
    cols_d     = cols_q;
    word_idx_d = word_idx_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    ser_load_c = 1'b0;
    ser_adv_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          rows_d     = n_rows;
          cols_d     = n_cols;
          word_idx_d = '0;
          tx_data_d  = {1'b0, n_rows};
          state_d    = HDR_R;
        end
      end
      HDR_R:   state_d = WAIT_H0;
      WAIT_H0: begin
        if (bus.uart_tx_done) begin
          tx_data_d = {1'b0, cols_q};
          state_d   = HDR_C;
        end
      end
      HDR_C:   state_d = WAIT_H1;
      WAIT_H1: begin
        if (bus.uart_tx_done) begin
          if (total_c == '0) begin
            state_d = FIN;
          end else begin
            addr_d  = word_idx_q;
            state_d = RD;
          end
        end
      end
      RD: begin
        lat_cnt_d = '0;
        state_d   = RD_WAIT;
      end
      // Address is stable during RD, so data lands RD_LAT cycles into RD_WAIT.
      RD_WAIT: begin
        if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
          ser_load_c = 1'b1;
          tx_data_d  = bus.ram_c_rd_data[DATA_W-1 -: 8];
          state_d    = SEND;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.uart_tx_done) begin
          if (!ser_last_c) begin
            ser_adv_c = 1'b1;
            tx_data_d = ser_next_byte_c;
            state_d   = SEND;
          end else if (!word_last_c) begin
            word_idx_d = word_idx_q + ADDR_W'(1);
            addr_d     = word_idx_q + ADDR_W'(1);
            state_d    = RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    send_d = (state_d == HDR_R) || (state_d == HDR_C) || (state_d == SEND);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      word_idx_q <= '0;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      word_idx_q <= word_idx_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ram_c_rd_addr  = addr_q;
  assign bus.uart_tx_data   = tx_data_q;
  assign bus.uart_send_data = send_q;
  assign busy               = busy_q;
  assign unload_done        = done_q;
  assign state_val          = state_q;

endmodule

// File: tb/tb_fsm_result_unload.sv
// Directed bench: two unload FSMs (RD_LAT 1 and 2) share stimulus, each with its own
// C-RAM model and UART responder; captured frames are compared to expected bytes.
module tb_fsm_result_unload;
  import fumpy_pkg::*;

  logic       clk, rst_n, start, clr, spur;
  logic [6:0] n_rows, n_cols;
  int         tx_delay, cyc;
  int         n_chk, n_err;

  logic [31:0] ram_mem [256];
  logic [7:0]  exp_q [$];

  fsm_result_unload_if #(.DATA_W(32), .ADDR_W(8)) bus0 ();
  fsm_result_unload_if #(.DATA_W(32), .ADDR_W(8)) bus1 ();

  logic       busy0, busy1, done0, done1;
  logic [3:0] st0, st1;

  fsm_result_unload #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_rows(n_rows), .n_cols(n_cols),
    .bus(bus0), .busy(busy0), .unload_done(done0), .state_val(st0));

  fsm_result_unload #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_rows(n_rows), .n_cols(n_cols),
    .bus(bus1), .busy(busy1), .unload_done(done1), .state_val(st1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // C-RAM models with registered output, latency 1 and 2
  logic [31:0] p0a, p1a, p1b;
  always @(posedge clk) begin
    p0a <= ram_mem[bus0.ram_c_rd_addr];
    p1a <= ram_mem[bus1.ram_c_rd_addr];
    p1b <= p1a;
  end
  assign bus0.ram_c_rd_data = p0a;
  assign bus1.ram_c_rd_data = p1b;

  // UART responders: tx_done tx_delay cycles after the strobe cycle
  int   cd0, cd1;
  logic txd0, txd1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd0 <= 0; txd0 <= 1'b0; cd1 <= 0; txd1 <= 1'b0;
    end else begin
      txd0 <= 1'b0;
      txd1 <= 1'b0;
      if (bus0.uart_send_data) begin
        if (tx_delay <= 1) txd0 <= 1'b1; else cd0 <= tx_delay - 1;
      end else if (cd0 > 0) begin
        cd0 <= cd0 - 1;
        if (cd0 == 1) txd0 <= 1'b1;
      end
      if (bus1.uart_send_data) begin
        if (tx_delay <= 1) txd1 <= 1'b1; else cd1 <= tx_delay - 1;
      end else if (cd1 > 0) begin
        cd1 <= cd1 - 1;
        if (cd1 == 1) txd1 <= 1'b1;
      end
    end
  end
  assign bus0.uart_tx_done = txd0 | (spur && (bus0.uart_send_data || st0 == 4'(RD)));
  assign bus1.uart_tx_done = txd1 | (spur && (bus1.uart_send_data || st1 == 4'(RD)));

  // Monitors: captured bytes, read addresses, done pulses, strobe spacing, hold errors
  logic [7:0] got0 [$], got1 [$], adr0 [$], adr1 [$];
  int ndone0, ndone1, gap0, gap1, last0, last1, hold0, hold1;
  always @(negedge clk) begin
    if (clr) begin
      got0.delete(); adr0.delete(); ndone0 = 0; gap0 = 1000; last0 = -1000;
      got1.delete(); adr1.delete(); ndone1 = 0; gap1 = 1000; last1 = -1000;
    end else begin
      if (txd0 && got0.size() > 0 && bus0.uart_tx_data != got0[got0.size()-1]) hold0++;
      if (txd1 && got1.size() > 0 && bus1.uart_tx_data != got1[got1.size()-1]) hold1++;
      if (bus0.uart_send_data) begin
        got0.push_back(bus0.uart_tx_data);
        if (cyc - last0 < gap0) gap0 = cyc - last0;
        last0 = cyc;
      end
      if (bus1.uart_send_data) begin
        got1.push_back(bus1.uart_tx_data);
        if (cyc - last1 < gap1) gap1 = cyc - last1;
        last1 = cyc;
      end
      if (st0 == 4'(RD)) adr0.push_back(bus0.ram_c_rd_addr);
      if (st1 == 4'(RD)) adr1.push_back(bus1.ram_c_rd_addr);
      if (done0) ndone0++;
      if (done1) ndone1++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic cmp_bytes(input string tag, input logic [7:0] act [$], input logic [7:0] expv [$]);
    int e0;
    chk({tag, "_len"}, 32'(act.size()), 32'(expv.size()));
    for (int i = 0; i < expv.size() && i < act.size(); i++) begin
      e0 = n_err;
      chk($sformatf("%s[%0d]", tag, i), 32'(act[i]), 32'(expv[i]));
      if (n_err != e0) break;
    end
  endtask

  function automatic void build_exp(input int r, input int c);
    int t;
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'(r));
    exp_q.push_back(8'(c));
    t = r * c;
    if (t > 256) t = 256;
    for (int i = 0; i < t; i++) begin
      w = ram_mem[i];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int r, input int c);
    start = 1'b0;
    n_rows = 7'(r);
    n_cols = 7'(c);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    start = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(ndone0 >= 1 && ndone1 >= 1) && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 20000), 32'd1);
    repeat (5) tick();
    start = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] t1_lit [18];
    int n;
    n_chk = 0; n_err = 0; cyc = 0; hold0 = 0; hold1 = 0;
    rst_n = 1'b0; start = 1'b0; clr = 1'b1; spur = 1'b0; tx_delay = 5;
    n_rows = '0; n_cols = '0;
    for (int i = 0; i < 256; i++)
      ram_mem[i] = {8'(i), 8'(~i), 8'(i * 3), 8'(i + 64)};
    ram_mem[0] = 32'h3F800000; ram_mem[1] = 32'h40000000;
    ram_mem[2] = 32'h40400000; ram_mem[3] = 32'h40800000;
    t1_lit = '{8'h02, 8'h02, 8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00,
               8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'h40, 8'h80, 8'h00, 8'h00};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_state", 32'(st0), 0);
    chk("rst_send", 32'(bus0.uart_send_data), 0);
    chk("rst_txdata", 32'(bus0.uart_tx_data), 0);
    chk("rst_addr", 32'(bus0.ram_c_rd_addr), 0);
    chk("rst_state1", 32'(st1), 0);
    rst_n = 1'b1;
    tick();

    // 1: 2x2 frame, tx_done 5 cycles after each strobe
    run_frame(2, 2);
    tick();
    tick();
    chk("t1_busy", 32'(busy0), 1);
    wait_done("t1");
    exp_q.delete();
    foreach (t1_lit[i]) exp_q.push_back(t1_lit[i]);
    cmp_bytes("t1_d0", got0, exp_q);
    cmp_bytes("t1_d1", got1, exp_q);
    chk("t1_ndone0", 32'(ndone0), 1);
    chk("t1_ndone1", 32'(ndone1), 1);
    chk("t1_gap0", 32'(gap0), 6);
    chk("t1_busy_end", 32'(busy0), 0);

    // 2: zero rows -> header only, RAM address untouched
    run_frame(0, 5);
    wait_done("t2");
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h05);
    cmp_bytes("t2_d0", got0, exp_q);
    chk("t2_ndone0", 32'(ndone0), 1);
    chk("t2_nrd0", 32'(adr0.size()), 0);
    chk("t2_addr0", 32'(bus0.ram_c_rd_addr), 3);
    chk("t2_addr1", 32'(bus1.ram_c_rd_addr), 3);

    // 3: 4x6, row-major addresses; latency-2 instance must latch the right word
    run_frame(4, 6);
    wait_done("t3");
    build_exp(4, 6);
    cmp_bytes("t3_d0", got0, exp_q);
    cmp_bytes("t3_d1", got1, exp_q);
    chk("t3_nrd1", 32'(adr1.size()), 24);
    for (int i = 0; i < adr1.size() && i < 24; i++)
      chk($sformatf("t3_addr1[%0d]", i), 32'(adr1[i]), 32'(i));

    // 4: re-start edge while busy plus spurious tx_done in SEND/RD
    spur = 1'b1;
    run_frame(3, 3);
    repeat (30) tick();
    chk("t4_busy", 32'(busy0), 1);
    start = 1'b0;
    tick();
    start = 1'b1;
    wait_done("t4");
    spur = 1'b0;
    repeat (20) tick();
    build_exp(3, 3);
    cmp_bytes("t4_d0", got0, exp_q);
    cmp_bytes("t4_d1", got1, exp_q);
    chk("t4_ndone0", 32'(ndone0), 1);
    chk("t4_idle", 32'(busy0), 0);

    // 5: reset during the 3rd data byte, then a clean frame
    run_frame(2, 2);
    n = 0;
    while (got0.size() < 5 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_reach", 32'(got0.size()), 5);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("t5_busy", 32'(busy0), 0);
    chk("t5_send", 32'(bus0.uart_send_data), 0);
    chk("t5_txdata", 32'(bus0.uart_tx_data), 0);
    chk("t5_addr", 32'(bus0.ram_c_rd_addr), 0);
    chk("t5_state", 32'(st0), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_frame(2, 2);
    wait_done("t5");
    exp_q.delete();
    foreach (t1_lit[i]) exp_q.push_back(t1_lit[i]);
    cmp_bytes("t5_d0", got0, exp_q);
    cmp_bytes("t5_d1", got1, exp_q);

    // 6: fastest UART, strobes 2 cycles apart
    tx_delay = 1;
    run_frame(3, 2);
    wait_done("t6");
    build_exp(3, 2);
    cmp_bytes("t6_d0", got0, exp_q);
    cmp_bytes("t6_d1", got1, exp_q);
    chk("t6_gap0", 32'(gap0), 2);
    chk("t6_gap1", 32'(gap1), 2);

    // 7: 20x20 = 400 words clamps to 256
    run_frame(20, 20);
    wait_done("t7");
    build_exp(20, 20);
    chk("t7_len_lit", 32'(got0.size()), 1026);
    cmp_bytes("t7_d0", got0, exp_q);
    chk("t7_nrd1", 32'(adr1.size()), 256);
    if (adr1.size() == 256) chk("t7_lastaddr", 32'(adr1[255]), 32'd255);

    chk("hold0", 32'(hold0), 0);
    chk("hold1", 32'(hold1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
